// File: rtl/fifo_read_skid_adapter_pkg.sv
// Shared defaults for the FIFO read-side skid adapter and its handshake interface.
package fifo_read_skid_adapter_pkg;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_COUNT_WIDTH = 16;
endpackage

// File: rtl/fifo_read_skid_adapter_if.sv
// FIFO read port plus downstream valid/ready stream seen by the skid adapter.
interface fifo_read_skid_adapter_if
    import fifo_read_skid_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    // master = adapter side, slave = FIFO/consumer environment side
    modport master (
        input  fifo_valid, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data
    );
    modport slave (
        output fifo_valid, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/fifo_read_skid_adapter.sv
// Drains a valid/pop FIFO into a registered valid/ready stream through a main+skid
// register pair; a flush FSM discards buffered entries and empties the FIFO.
module fifo_read_skid_adapter
    import fifo_read_skid_adapter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_read_skid_adapter_if.master bus,
    input  logic                   flush,
    output logic                   flush_busy,
    output logic [COUNT_WIDTH-1:0] delivered_count
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  main_valid;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  pop;
    logic                  handshake;
    logic                  idle_run;
    logic                  load_main_fifo;
    logic                  load_skid;
    logic                  load_main_skid;

    // Pop depends only on registered state and FIFO status, never on out_ready.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                pop = bus.fifo_valid & ~skid_valid & ~flush & ~rst;
                if (flush) state_nxt = DRAIN;
            end
            DRAIN: begin
                pop = bus.fifo_valid & ~rst;
                if (~bus.fifo_valid & ~flush) state_nxt = IDLE;
            end
        endcase
    end

    assign bus.fifo_pop  = pop;
    assign bus.out_valid = main_valid & (state == IDLE);
    assign bus.out_data  = main_data;
    assign flush_busy    = (state == DRAIN);

    assign handshake      = bus.out_valid & bus.out_ready;
    assign idle_run       = (state == IDLE) & ~flush;
    assign load_main_fifo = idle_run & pop & (~main_valid | bus.out_ready);
    assign load_skid      = idle_run & pop & main_valid & ~bus.out_ready;
    assign load_main_skid = idle_run & ~pop & skid_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            main_valid      <= 1'b0;
            skid_valid      <= 1'b0;
            delivered_count <= '0;
        end else begin
            state <= state_nxt;
            // A handshake in the flush cycle still counts as delivered.
            if (handshake) delivered_count <= delivered_count + 1'b1;
            if ((state == IDLE) && flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (load_main_fifo || load_main_skid) main_valid <= 1'b1;
                else if (handshake)                   main_valid <= 1'b0;
                if (load_skid)           skid_valid <= 1'b1;
                else if (load_main_skid) skid_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_main_fifo)      main_data <= bus.fifo_data;
        else if (load_main_skid) main_data <= skid_data;
        if (load_skid)           skid_data <= bus.fifo_data;
    end

    // Upstream FIFO must never be popped while empty.
    a_pop_needs_valid: assert property (@(posedge clk) disable iff (rst)
        bus.fifo_pop |-> bus.fifo_valid);

endmodule

// File: tb/tb_fifo_read_skid_adapter.sv
// Randomized and directed bench for fifo_read_skid_adapter against a queue-based model.
module tb_fifo_read_skid_adapter;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          flush_busy;
    logic [CW-1:0] delivered_count;

    fifo_read_skid_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_read_skid_adapter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .flush          (flush),
        .flush_busy     (flush_busy),
        .delivered_count(delivered_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] m_buf[$];
    bit            m_drain = 1'b0;
    int            m_count = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance the model.
    task automatic cycle(input bit r, input bit f, input bit rdy);
        bit            src_ne;
        bit            exp_valid;
        bit            exp_pop;
        bit            hs;
        logic [DW-1:0] v;
        rst           = r;
        flush         = f;
        bus.out_ready = rdy;
        src_ne        = (src.size() > 0);
        bus.fifo_valid = src_ne;
        bus.fifo_data  = src_ne ? src[0] : DW'($urandom);
        exp_valid = !m_drain && (m_buf.size() > 0);
        exp_pop   = !r && src_ne && (m_drain || ((m_buf.size() < 2) && !f));
        @(negedge clk);
        check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_valid});
        if (exp_valid) check_eq("out_data", {32'd0, bus.out_data}, {32'd0, m_buf[0]});
        check_eq("fifo_pop", {63'd0, bus.fifo_pop}, {63'd0, exp_pop});
        check_eq("flush_busy", {63'd0, flush_busy}, {63'd0, m_drain});
        check_eq("delivered_count", {60'd0, delivered_count}, 64'(m_count));
        @(posedge clk);
        if (r) begin
            m_buf.delete();
            m_drain = 1'b0;
            m_count = 0;
        end else begin
            hs = exp_valid && rdy;
            if (hs) begin
                void'(m_buf.pop_front());
                m_count = (m_count + 1) % (1 << CW);
            end
            if (exp_pop) begin
                v = src.pop_front();
                if (!m_drain) m_buf.push_back(v);
            end
            if (!m_drain && f) begin
                m_buf.delete();
                m_drain = 1'b1;
            end else if (m_drain && !src_ne && !f) begin
                m_drain = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        src.delete();
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.fifo_valid = 1'b0;
        bus.fifo_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming at full rate
        for (int i = 0; i < 4; i++) src.push_back(DW'(32'h10 + i));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);

        // Backpressure fills main+skid, then releases in order
        do_reset();
        for (int i = 0; i < 4; i++) src.push_back(DW'(32'hA0 + i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);

        // Alternating ready with a continuously valid FIFO
        do_reset();
        for (int i = 0; i < 8; i++) src.push_back(DW'(i));
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, (i % 2) == 0);

        // Flush with both registers full and 3 queued entries, then resume
        do_reset();
        src.push_back(32'h30);
        src.push_back(32'h31);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) src.push_back(DW'(32'h32 + i));
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        src.push_back(32'h55);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // Reset while draining with entries still queued
        do_reset();
        for (int i = 0; i < 6; i++) src.push_back(DW'(32'h60 + i));
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        src.delete();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);

        // Counter wrap: 17 handshakes on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) src.push_back(DW'(32'h100 + i));
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1);
        check_eq("count_wrap", {60'd0, delivered_count}, 64'd1);

        // Random traffic with occasional flush and reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 55 && src.size() < 8) src.push_back($urandom);
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
